logic_circuit: RTL and testbench

//   Three-input Boolean function block with a registered observation path.

---
 rtl/logic_circuit_pkg.sv | 11 +
 rtl/logic_circuit_lut.sv | 15 +
 rtl/logic_circuit.sv | 87 ++++++++
 tb/tb_logic_circuit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/logic_circuit_pkg.sv
// Shared constants and the LUT helper for the logic_circuit block.
package logic_circuit_pkg;

  localparam logic [7:0] LC_MAJ3_TT   = 8'hE8;
  localparam int         LC_CNT_W_DEF = 8;

  function automatic logic lc_lut(input logic [7:0] tt, input logic [2:0] idx);
    return tt[idx];
  endfunction

endpackage

// File: rtl/logic_circuit_lut.sv
// Combinational 8:1 select of a truth table by {a,b,c}; a is the index MSB.
module logic_circuit_lut
  import logic_circuit_pkg::*;
#(
  parameter logic [7:0] TRUTH_TABLE = LC_MAJ3_TT
) (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic f_o
);

  assign f_o = lc_lut(TRUTH_TABLE, {a_i, b_i, c_i});

endmodule

// File: rtl/logic_circuit.sv
// Three-input LUT function with registered copy, edge pulses and an optional
// saturating toggle counter (enabled by LOGIC_CIRCUIT_TOGGLE_CNT_EN).
module logic_circuit
  import logic_circuit_pkg::*;
#(
  parameter logic [7:0] TRUTH_TABLE = LC_MAJ3_TT,
  parameter int         CNT_W       = LC_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             cnt_clr,
  output logic             F,
  output logic             f_q,
  output logic             f_rise,
  output logic             f_fall,
  output logic [CNT_W-1:0] toggle_cnt
);

  logic fq_q, fq_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  logic_circuit_lut #(
    .TRUTH_TABLE(TRUTH_TABLE)
  ) u_lut (
    .a_i(A),
    .b_i(B),
    .c_i(C),
    .f_o(F)
  );

  always_comb begin
    fq_d   = F;
    rise_d = F & ~fq_q;
    fall_d = ~F & fq_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      fq_q   <= fq_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign f_q    = fq_q;
  assign f_rise = rise_q;
  assign f_fall = fall_q;

`ifdef LOGIC_CIRCUIT_TOGGLE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear outranks a simultaneous toggle; increments stop at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (F != fq_q) begin
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign toggle_cnt = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign toggle_cnt     = '0;
`endif

endmodule

// File: tb/tb_logic_circuit.sv
// Directed self-checking bench for logic_circuit (majority and XOR tables).
module tb_logic_circuit;

`ifdef LOGIC_CIRCUIT_TOGGLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       A, B, C, cnt_clr;
  logic       F, f_q, f_rise, f_fall;
  logic [7:0] toggle_cnt;
  logic       F_x, fq_x, rise_x, fall_x;
  logic [7:0] cnt_x;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  logic_circuit dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .cnt_clr(cnt_clr),
    .F(F), .f_q(f_q), .f_rise(f_rise), .f_fall(f_fall), .toggle_cnt(toggle_cnt)
  );

  logic_circuit #(.TRUTH_TABLE(8'h96), .CNT_W(8)) dut_xor (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .cnt_clr(cnt_clr),
    .F(F_x), .f_q(fq_x), .f_rise(rise_x), .f_fall(fall_x), .toggle_cnt(cnt_x)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_cnt(input int v);
    if (!CNT_EN) return 8'd0;
    return (v > 255) ? 8'd255 : 8'(v);
  endfunction

  task automatic test_sweep();
    logic [7:0] maj_exp;
    logic [7:0] xor_exp;
    maj_exp = 8'b1110_1000;  // ABC=111..000, MSB first
    xor_exp = 8'b1001_0110;
    for (int i = 0; i < 8; i++) begin
      {A, B, C} = 3'(i);
      #1;
      n_checks++;
      if (F !== maj_exp[i]) begin
        n_fail++;
        $display("FAIL sweep_maj abc=%03b got F=%b want %b", 3'(i), F, maj_exp[i]);
      end
      n_checks++;
      if (F_x !== xor_exp[i]) begin
        n_fail++;
        $display("FAIL sweep_xor abc=%03b got F=%b want %b", 3'(i), F_x, xor_exp[i]);
      end
    end
  endtask

  task automatic test_reset();
    {A, B, C} = 3'b111;
    cnt_clr = 1'b0;
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({F, f_q, f_rise, f_fall, toggle_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_state got F=%b fq=%b r=%b f=%b cnt=%0d want F=1 rest 0",
               F, f_q, f_rise, f_fall, toggle_cnt);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({f_q, f_rise, f_fall, toggle_cnt} !== {1'b1, 1'b1, 1'b0, exp_cnt(1)}) begin
      n_fail++;
      $display("FAIL first_edge got fq=%b r=%b f=%b cnt=%0d want 1 1 0 %0d",
               f_q, f_rise, f_fall, toggle_cnt, exp_cnt(1));
    end
    tick();
    n_checks++;
    if ({f_q, f_rise, f_fall, toggle_cnt} !== {1'b1, 1'b0, 1'b0, exp_cnt(1)}) begin
      n_fail++;
      $display("FAIL hold_edge got fq=%b r=%b f=%b cnt=%0d want 1 0 0 %0d",
               f_q, f_rise, f_fall, toggle_cnt, exp_cnt(1));
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({F, f_q, f_rise, f_fall, toggle_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL midop_reset got F=%b fq=%b r=%b f=%b cnt=%0d want F=1 rest 0",
               F, f_q, f_rise, f_fall, toggle_cnt);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_toggle_sat();
    logic er, ef;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      {A, B, C} = (k % 2 == 1) ? 3'b011 : 3'b001;
      tick();
      er = (k % 2 == 1);
      ef = (k % 2 == 0);
      n_checks++;
      if ({f_q, f_rise, f_fall, toggle_cnt} !== {er, er, ef, exp_cnt(k)}) begin
        n_fail++;
        $display("FAIL toggle k=%0d got fq=%b r=%b f=%b cnt=%0d want %b %b %b %0d",
                 k, f_q, f_rise, f_fall, toggle_cnt, er, er, ef, exp_cnt(k));
      end
    end
  endtask

  task automatic test_clear();
    {A, B, C} = 3'b011;
    cnt_clr = 1'b1;
    tick();
    n_checks++;
    if ({f_q, f_rise, f_fall, toggle_cnt} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL clear_vs_toggle got fq=%b r=%b f=%b cnt=%0d want 1 1 0 0",
               f_q, f_rise, f_fall, toggle_cnt);
    end
    cnt_clr = 1'b0;
    {A, B, C} = 3'b001;
    tick();
    n_checks++;
    if ({f_q, f_rise, f_fall, toggle_cnt} !== {1'b0, 1'b0, 1'b1, exp_cnt(1)}) begin
      n_fail++;
      $display("FAIL count_after_clear got fq=%b r=%b f=%b cnt=%0d want 0 0 1 %0d",
               f_q, f_rise, f_fall, toggle_cnt, exp_cnt(1));
    end
    {A, B, C} = 3'b011;
    #3;
    {A, B, C} = 3'b001;
    tick();
    n_checks++;
    if ({f_q, f_rise, f_fall, toggle_cnt} !== {1'b0, 1'b0, 1'b0, exp_cnt(1)}) begin
      n_fail++;
      $display("FAIL glitch_ignored got fq=%b r=%b f=%b cnt=%0d want 0 0 0 %0d",
               f_q, f_rise, f_fall, toggle_cnt, exp_cnt(1));
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    n_checks++;
    if (toggle_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL clear_idle got cnt=%0d want 0", toggle_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cnt_clr = 1'b0;
    {A, B, C} = 3'b000;
    test_sweep();
    test_reset();
    test_toggle_sat();
    test_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
